// File: rtl/mips_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_inst_encoder
// Brief    : Packs instruction fields into 32-bit MIPS words, buffers them in
//            a 2-entry FIFO and drains them to instruction memory at
//            auto-incrementing word addresses. Optional ENC_CHECKSUM_EN adds
//            a running XOR of every word written to memory.
// Revision : 1.0 - initial release
// ============================================================================
module mips_inst_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_wr_en,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
`ifdef ENC_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              err
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [ADDR_W-1:0] c_ADDR_STEP = ADDR_W'(4);

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;

    logic [31:0]       r_fifo [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    always_comb begin
        w_word  = 32'd0;
        w_legal = 1'b1;
        case (op_sel)
            4'd0:  w_word = {c_OP_RTYPE, rs, rt, rd, 5'd0, 6'h20};
            4'd1:  w_word = {c_OP_RTYPE, rs, rt, rd, 5'd0, 6'h22};
            4'd2:  w_word = {c_OP_RTYPE, rs, rt, rd, 5'd0, 6'h24};
            4'd3:  w_word = {c_OP_RTYPE, rs, rt, rd, 5'd0, 6'h25};
            4'd4:  w_word = {c_OP_RTYPE, rs, rt, rd, 5'd0, 6'h2A};
            4'd5:  w_word = {c_OP_RTYPE, 5'd0, rt, rd, shamt, 6'h00};
            4'd6:  w_word = {c_OP_ADDI, rs, rt, imm};
            4'd7:  w_word = {c_OP_LW, rs, rt, imm};
            4'd8:  w_word = {c_OP_SW, rs, rt, imm};
            4'd9:  w_word = {c_OP_BEQ, rs, rt, imm};
            4'd10: w_word = {c_OP_BNE, rs, rt, imm};
            4'd11: w_word = {c_OP_J, target};
            default: w_legal = 1'b0;
        endcase
    end

    assign w_full    = (r_count == 2'd2);
    assign w_empty   = (r_count == 2'd0);
    assign in_ready  = !w_full && !restart;
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && w_legal;
    assign mem_wr_en = !w_empty;
    // restart masks the pop so no write is reported as completed that cycle
    assign w_pop     = mem_wr_en && mem_ready && !restart;

    assign mem_data  = w_empty ? 32'd0 : r_fifo[r_rd_ptr];
    assign mem_addr  = r_addr;
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo[0] <= 32'd0;
            r_fifo[1] <= 32'd0;
            r_rd_ptr  <= 1'b0;
            r_wr_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_addr    <= BASE_ADDR;
            r_err     <= 1'b0;
        end else if (restart) begin
            r_rd_ptr  <= 1'b0;
            r_wr_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_addr    <= BASE_ADDR;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_word;
                r_wr_ptr         <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
                r_addr   <= r_addr + c_ADDR_STEP;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

`ifdef ENC_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= 32'd0;
        end else if (restart) begin
            r_checksum <= 32'd0;
        end else if (w_pop) begin
            r_checksum <= r_checksum ^ mem_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_inst_encoder
// Brief    : Directed self-checking bench for mips_inst_encoder; a second,
//            narrow-address instance shares the stimulus to exercise wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_inst_encoder;

    localparam logic [31:0] c_BASE = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        restart;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [3:0]  op_sel;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic        mem_wr_en, mem_wr_en2;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_addr2;
    logic [31:0] mem_data, mem_data2;
    logic        err, err2;
`ifdef ENC_CHECKSUM_EN
    logic [31:0] checksum, checksum2;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    mips_inst_encoder #(.ADDR_W(32), .BASE_ADDR(c_BASE)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .target(target),
        .mem_wr_en(mem_wr_en), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data),
`ifdef ENC_CHECKSUM_EN
        .checksum(checksum),
`endif
        .err(err)
    );

    mips_inst_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready2),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .target(target),
        .mem_wr_en(mem_wr_en2), .mem_ready(mem_ready),
        .mem_addr(mem_addr2), .mem_data(mem_data2),
`ifdef ENC_CHECKSUM_EN
        .checksum(checksum2),
`endif
        .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                         input logic [15:0] im, input logic [25:0] tg);
        in_valid = v; op_sel = op; rs = s; rt = t; rd = d; shamt = sh;
        imm = im; target = tg;
    endtask

    initial begin
        rst_n = 1'b0; restart = 1'b0; mem_ready = 1'b0;
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        tick(); tick();
        check("rst_wr_en", mem_wr_en, 1'b0);
        check("rst_data", mem_data, 32'd0);
        check("rst_addr", mem_addr, c_BASE);
        check("rst_err", err, 1'b0);
        check("rst_addr_narrow", mem_addr2, 4'hC);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1'b1);

        // ADDI rs=0 rt=5 imm=1
        mem_ready = 1'b1;
        drive(1'b1, 4'd6, 5'd0, 5'd5, 5'd0, 5'd0, 16'h0001, 26'd0);
        tick();
        in_valid = 1'b0;
        check("addi_wr_en", mem_wr_en, 1'b1);
        check("addi_data", mem_data, 32'h2005_0001);
        check("addi_addr", mem_addr, c_BASE);
        check("addi_addr_narrow", mem_addr2, 4'hC);
        tick();
        check("addi_drained", mem_wr_en, 1'b0);
        check("empty_data", mem_data, 32'd0);
        check("addr_inc", mem_addr, c_BASE + 32'd4);
        check("addr_wrap_narrow", mem_addr2, 4'h0);
`ifdef ENC_CHECKSUM_EN
        check("checksum_one", checksum, 32'h2005_0001);
`endif

        // ADD, then SLL and J with push and pop overlapping at occupancy 1
        drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 5'd5, 16'd0, 26'd0);
        tick();
        check("add_data", mem_data, 32'h0022_1820);
        check("add_addr_narrow", mem_addr2, 4'h0);
        drive(1'b1, 4'd5, 5'd7, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0);
        check("sll_ready", in_ready, 1'b1);
        tick();
        check("sll_data", mem_data, 32'h0002_1900);
        check("sll_addr", mem_addr, c_BASE + 32'd8);
        drive(1'b1, 4'd11, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
        tick();
        in_valid = 1'b0;
        check("j_data", mem_data, 32'h0800_0010);
        check("j_addr", mem_addr, c_BASE + 32'd12);
        tick();
        check("j_drained", mem_wr_en, 1'b0);
        check("j_addr_after", mem_addr, c_BASE + 32'd16);

        // backpressure: LW, SW, BEQ back-to-back with memory stalled
        mem_ready = 1'b0;
        drive(1'b1, 4'd7, 5'd4, 5'd6, 5'd0, 5'd0, 16'h0010, 26'd0);
        tick();
        drive(1'b1, 4'd8, 5'd4, 5'd7, 5'd0, 5'd0, 16'hFFFC, 26'd0);
        check("bp_ready_1", in_ready, 1'b1);
        tick();
        drive(1'b1, 4'd9, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0003, 26'd0);
        check("bp_full", in_ready, 1'b0);
        check("bp_data", mem_data, 32'h8C86_0010);
        check("bp_addr", mem_addr, c_BASE + 32'd16);
        tick();
        check("bp_full_hold", in_ready, 1'b0);
        check("bp_data_hold", mem_data, 32'h8C86_0010);
        check("bp_addr_hold", mem_addr, c_BASE + 32'd16);
        check("bp_wr_en_hold", mem_wr_en, 1'b1);
        mem_ready = 1'b1;
        tick();
        check("bp_sw_data", mem_data, 32'hAC87_FFFC);
        check("bp_sw_addr", mem_addr, c_BASE + 32'd20);
        check("bp_ready_again", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("bp_beq_data", mem_data, 32'h1022_0003);
        check("bp_beq_addr", mem_addr, c_BASE + 32'd24);
        tick();
        check("bp_drained", mem_wr_en, 1'b0);
        check("bp_addr_end", mem_addr, c_BASE + 32'd28);

        // illegal op_sel
        drive(1'b1, 4'd13, 5'd1, 5'd2, 5'd3, 5'd0, 16'h1234, 26'd0);
        check("ill_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("ill_err", err, 1'b1);
        check("ill_no_write", mem_wr_en, 1'b0);
        check("ill_addr", mem_addr, c_BASE + 32'd28);
        tick();
        check("ill_err_pulse", err, 1'b0);
        check("ill_no_write_2", mem_wr_en, 1'b0);

        // restart with two words queued and a valid input
        mem_ready = 1'b0;
        drive(1'b1, 4'd10, 5'd3, 5'd0, 5'd0, 5'd0, 16'h0001, 26'd0);
        tick();
        drive(1'b1, 4'd3, 5'd1, 5'd2, 5'd4, 5'd0, 16'd0, 26'd0);
        tick();
        check("bne_data", mem_data, 32'h1460_0001);
        drive(1'b1, 4'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0);
        mem_ready = 1'b1;
        restart = 1'b1;
        #1;
        check("rs_in_ready", in_ready, 1'b0);
        tick();
        restart = 1'b0; in_valid = 1'b0;
        check("rs_wr_en", mem_wr_en, 1'b0);
        check("rs_data", mem_data, 32'd0);
        check("rs_addr", mem_addr, c_BASE);
        check("rs_err", err, 1'b0);
        check("rs_addr_narrow", mem_addr2, 4'hC);
`ifdef ENC_CHECKSUM_EN
        check("rs_checksum", checksum, 32'd0);
`endif

        // reset while a word is pending
        mem_ready = 1'b0;
        drive(1'b1, 4'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
        tick();
        in_valid = 1'b0;
        check("and_data", mem_data, 32'h0022_1824);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", mem_wr_en, 1'b0);
        check("mid_rst_data", mem_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_addr", mem_addr, c_BASE);
        check("post_rst_wr_en", mem_wr_en, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
